// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O port: word width, default sizing and
// the interrupt sequencer state encoding.
package cpu_io_pkg;

    localparam int WORD_W      = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_HOLDOFF = 3;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2,
        HOLD     = 2'd3
    } irqState_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Small synchronous show-ahead FIFO for inbound words. The head word is
// visible combinationally whenever the FIFO holds data and reads as zero
// when empty. Pushes while full and pops while empty are ignored.
module io_sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WORD_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [WORD_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] memQ [DEPTH];
    logic [AW-1:0]     wrPtrQ, wrPtrD;
    logic [AW-1:0]     rdPtrQ, rdPtrD;
    logic [AW:0]       countQ, countD;
    logic              pushOk;
    logic              popOk;

    assign full_o  = (countQ == (AW + 1)'(DEPTH));
    assign empty_o = (countQ == '0);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign count_o = countQ;
    assign head_o  = empty_o ? '0 : memQ[rdPtrQ];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (pushOk) wrPtrD = wrPtrQ + 1'b1;
        if (popOk)  rdPtrD = rdPtrQ + 1'b1;
        if (pushOk && !popOk)      countD = countQ + 1'b1;
        else if (popOk && !pushOk) countD = countQ - 1'b1;
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    // Storage array; contents are don't-care when not covered by the count.
    always_ff @(posedge clk) begin
        if (pushOk) memQ[wrPtrQ] <= data_i;
    end

endmodule

// File: rtl/cpu_io_port.sv
// CPU I/O port: inbound FIFO with a one-pulse-per-word interrupt sequencer,
// and an outbound single-word register with a sticky overflow flag.
// Optional macro CPU_IO_IRQ_TIMEOUT_EN: re-pulse the interrupt after
// TIMEOUT cycles without an acknowledge.
module cpu_io_port
    import cpu_io_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [WORD_W-1:0]        cpu_data_in,
    output logic                     interrupt,
    input  logic                     int_ack,
    input  logic                     irq_mask,
    input  logic [WORD_W-1:0]        cpu_data_out,
    input  logic                     cpu_out_wr,
    output logic [WORD_W-1:0]        ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic                     overflow
);

    localparam int CNT_MAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic              fifoFull;
    logic              fifoEmpty;
    irqState_e         stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [WORD_W-1:0] outDataQ, outDataD;
    logic              outValidQ, outValidD;
    logic              overflowQ, overflowD;

    io_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ext_in_valid),
        .data_i  (ext_in_data),
        .pop_i   (int_ack),
        .head_o  (cpu_data_in),
        .count_o (in_count),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign ext_in_ready = !fifoFull;
    assign interrupt    = (stateQ == PULSE);

    // Interrupt sequencer state and shared hold-off / timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // One pulse per queued word; an ack starts a hold-off so the CPU
    // pipeline can drain before the next interrupt.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            IDLE: begin
                if (!fifoEmpty && !irq_mask) stateD = PULSE;
            end
            PULSE: begin
                if (int_ack) begin
                    stateD = HOLD;
                    cntD   = CNT_W'(HOLDOFF);
                end else begin
                    stateD = WAIT_ACK;
`ifdef CPU_IO_IRQ_TIMEOUT_EN
                    cntD   = CNT_W'(TIMEOUT - 1);
`endif
                end
            end
            WAIT_ACK: begin
                if (int_ack) begin
                    stateD = HOLD;
                    cntD   = CNT_W'(HOLDOFF);
                end
`ifdef CPU_IO_IRQ_TIMEOUT_EN
                else if (cntQ == '0) begin
                    stateD = PULSE;
                end else begin
                    cntD = cntQ - 1'b1;
                end
`endif
            end
            HOLD: begin
                if (cntQ == '0) stateD = IDLE;
                else            cntD   = cntQ - 1'b1;
            end
            default: stateD = IDLE;
        endcase
    end

    // Outbound register: accept a write when empty or draining this cycle,
    // otherwise drop it and flag overflow until the next reset.
    always_comb begin
        outDataD  = outDataQ;
        outValidD = outValidQ;
        overflowD = overflowQ;
        if (cpu_out_wr) begin
            if (!outValidQ || ext_out_ready) begin
                outDataD  = cpu_data_out;
                outValidD = 1'b1;
            end else begin
                overflowD = 1'b1;
            end
        end else if (outValidQ && ext_out_ready) begin
            outValidD = 1'b0;
        end
    end

    // Outbound register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            outDataQ  <= '0;
            outValidQ <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            outDataQ  <= outDataD;
            outValidQ <= outValidD;
            overflowQ <= overflowD;
        end
    end

    assign ext_out_data  = outDataQ;
    assign ext_out_valid = outValidQ;
    assign overflow      = overflowQ;

endmodule

// File: tb/tb_cpu_io_port.sv
// Self-checking bench for cpu_io_port: directed interrupt/FIFO/outbound
// scenarios followed by a randomized phase against a queue-based model.
module tb_cpu_io_port;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 3;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ext_in_data = '0;
    logic        ext_in_valid = 1'b0;
    logic        ext_in_ready;
    logic [15:0] cpu_data_in;
    logic        interrupt;
    logic        int_ack = 1'b0;
    logic        irq_mask = 1'b0;
    logic [15:0] cpu_data_out = '0;
    logic        cpu_out_wr = 1'b0;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready = 1'b0;
    logic [2:0]  in_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] refQ [$];
    logic        refOutValid = 1'b0;
    logic [15:0] refOutData = '0;
    logic        refOvf = 1'b0;

    cpu_io_port #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .cpu_data_in   (cpu_data_in),
        .interrupt     (interrupt),
        .int_ack       (int_ack),
        .irq_mask      (irq_mask),
        .cpu_data_out  (cpu_data_out),
        .cpu_out_wr    (cpu_out_wr),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count),
        .overflow      (overflow)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every data-path output against the reference model.
    task automatic checkDatapath(input string phase);
        logic [15:0] expHead;
        expHead = (refQ.size() > 0) ? refQ[0] : 16'h0000;
        checkOutput({phase, "_in_count"}, 32'(in_count), 32'(refQ.size()));
        checkOutput({phase, "_in_ready"}, 32'(ext_in_ready), 32'(refQ.size() < DEPTH));
        checkOutput({phase, "_data_in"}, 32'(cpu_data_in), 32'(expHead));
        checkOutput({phase, "_out_valid"}, 32'(ext_out_valid), 32'(refOutValid));
        checkOutput({phase, "_out_data"}, 32'(ext_out_data), 32'(refOutData));
        checkOutput({phase, "_overflow"}, 32'(overflow), 32'(refOvf));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic ack,
                                 input logic msk, input logic wr, input logic [15:0] wd,
                                 input logic ordy, input string phase);
        logic        doPush;
        logic        doPop;
        logic [15:0] dummy;
        ext_in_valid  = v;
        ext_in_data   = d;
        int_ack       = ack;
        irq_mask      = msk;
        cpu_out_wr    = wr;
        cpu_data_out  = wd;
        ext_out_ready = ordy;
        doPush = v && (refQ.size() < DEPTH);
        doPop  = ack && (refQ.size() > 0);
        if (doPop) dummy = refQ.pop_front();
        if (doPush) refQ.push_back(d);
        if (wr) begin
            if (!refOutValid || ordy) begin
                refOutValid = 1'b1;
                refOutData  = wd;
            end else begin
                refOvf = 1'b1;
            end
        end else if (refOutValid && ordy) begin
            refOutValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkDatapath(phase);
    endtask

    task automatic doReset();
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
        int_ack       = 1'b0;
        irq_mask      = 1'b0;
        cpu_out_wr    = 1'b0;
        cpu_data_out  = '0;
        ext_out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        refQ.delete();
        refOutValid = 1'b0;
        refOutData  = '0;
        refOvf      = 1'b0;
    endtask

    initial begin
        int pulses;
        int lastPulse;
        int gap;
        logic ackNext;
        logic found;
        logic prevIrq;
        int pulseAt [$];

        // ---- reset state ----
        reset = 1'b1;
        @(posedge clk);
        #1;
        doReset();
        checkOutput("rst_in_count", 32'(in_count), 0);
        checkOutput("rst_in_ready", 32'(ext_in_ready), 1);
        checkOutput("rst_data_in", 32'(cpu_data_in), 0);
        checkOutput("rst_interrupt", 32'(interrupt), 0);
        checkOutput("rst_out_valid", 32'(ext_out_valid), 0);
        checkOutput("rst_out_data", 32'(ext_out_data), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);

        // ---- single word, pulse latency, hold-off ----
        applyStimulus(1, 16'hA5A5, 0, 0, 0, 0, 0, "t1");
        checkOutput("t1_head", 32'(cpu_data_in), 32'h0000A5A5);
        checkOutput("t1_irq_early", 32'(interrupt), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "t1");
        checkOutput("t1_irq_pulse", 32'(interrupt), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "t1");
        checkOutput("t1_irq_width", 32'(interrupt), 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, "t1");
        checkOutput("t1_pop_count", 32'(in_count), 0);
        checkOutput("t1_pop_head", 32'(cpu_data_in), 0);
        checkOutput("t1_hold_irq", 32'(interrupt), 0);
        applyStimulus(1, 16'h5A5A, 0, 0, 0, 0, 0, "t1");
        checkOutput("t1_hold_irq", 32'(interrupt), 0);
        for (int i = 0; i < HOLDOFF - 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, "t1");
            checkOutput("t1_hold_irq", 32'(interrupt), 0);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, "t1");
            if (interrupt) found = 1'b1;
        end
        checkOutput("t1_second_pulse", 32'(found), 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, "t1");

        // ---- fill to DEPTH, back-pressure, ordering ----
        doReset();
        for (int k = 1; k <= 4; k++) applyStimulus(1, 16'(k), 0, 1, 0, 0, 0, "t2");
        checkOutput("t2_ready_full", 32'(ext_in_ready), 0);
        applyStimulus(1, 16'd5, 0, 1, 0, 0, 0, "t2");
        applyStimulus(1, 16'd5, 0, 1, 0, 0, 0, "t2");
        checkOutput("t2_full_count", 32'(in_count), 4);
        checkOutput("t2_full_head", 32'(cpu_data_in), 1);
        applyStimulus(1, 16'd5, 1, 1, 0, 0, 0, "t2");
        checkOutput("t2_full_pop_count", 32'(in_count), 3);
        checkOutput("t2_full_pop_head", 32'(cpu_data_in), 2);
        applyStimulus(1, 16'd5, 0, 1, 0, 0, 0, "t2");
        checkOutput("t2_fifth_in", 32'(in_count), 4);
        for (int k = 2; k <= 5; k++) begin
            checkOutput("t2_order", 32'(cpu_data_in), 32'(k));
            applyStimulus(0, 0, 1, 1, 0, 0, 0, "t2");
        end
        checkOutput("t2_drained", 32'(in_count), 0);

        // ---- masking, then exactly two spaced pulses ----
        doReset();
        applyStimulus(1, 16'h0011, 0, 1, 0, 0, 0, "t3");
        applyStimulus(1, 16'h0022, 0, 1, 0, 0, 0, "t3");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0, "t3");
            checkOutput("t3_masked_irq", 32'(interrupt), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "t3");
        checkOutput("t3_unmask_pulse", 32'(interrupt), 1);
        pulses = 1;
        lastPulse = 0;
        gap = 0;
        ackNext = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(0, 0, ackNext, 0, 0, 0, 0, "t3");
            ackNext = interrupt;
            if (interrupt) begin
                pulses++;
                gap = c - lastPulse;
                lastPulse = c;
            end
        end
        checkOutput("t3_pulse_total", 32'(pulses), 2);
        checkOutput("t3_gap_ok", 32'(gap >= HOLDOFF + 2), 1);
        checkOutput("t3_empty", 32'(in_count), 0);

        // ---- outbound overflow ----
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 16'h1234, 0, "t4");
        checkOutput("t4_valid", 32'(ext_out_valid), 1);
        applyStimulus(0, 0, 0, 0, 1, 16'h5678, 0, "t4");
        checkOutput("t4_data_held", 32'(ext_out_data), 32'h1234);
        checkOutput("t4_overflow", 32'(overflow), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "t4");
        checkOutput("t4_drain", 32'(ext_out_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "t4");
        checkOutput("t4_ovf_sticky", 32'(overflow), 1);
        doReset();
        checkOutput("t4_ovf_reset", 32'(overflow), 0);

        // ---- write on the same cycle as a drain ----
        applyStimulus(0, 0, 0, 0, 1, 16'hAAAA, 0, "t5");
        applyStimulus(0, 0, 0, 0, 1, 16'hBBBB, 1, "t5");
        checkOutput("t5_valid", 32'(ext_out_valid), 1);
        checkOutput("t5_data", 32'(ext_out_data), 32'hBBBB);
        checkOutput("t5_no_ovf", 32'(overflow), 0);

        // ---- unacknowledged interrupt ----
        doReset();
        applyStimulus(1, 16'h0F0F, 0, 0, 0, 0, 0, "t6");
        pulseAt.delete();
        for (int c = 0; c < 3 * (TIMEOUT + 1) + 10; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, "t6");
            if (interrupt) pulseAt.push_back(c);
        end
`ifdef CPU_IO_IRQ_TIMEOUT_EN
        checkOutput("t6_repulse_count", 32'(pulseAt.size() >= 3), 1);
        for (int i = 1; i < pulseAt.size(); i++)
            checkOutput("t6_repulse_period", 32'(pulseAt[i] - pulseAt[i-1]), 32'(TIMEOUT + 1));
`else
        checkOutput("t6_single_pulse", 32'(pulseAt.size()), 1);
`endif

        // ---- randomized traffic against the model ----
        doReset();
        prevIrq = 1'b0;
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 1)), "rnd");
            if (prevIrq) checkOutput("rnd_irq_one_cycle", 32'(interrupt), 0);
            prevIrq = interrupt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Peripheral on the far side of the CPU's data_in / data_out / interrupt pins.
- Inbound: buffers words from an external valid/ready stream in a small FIFO, presents the head word on cpu_data_in, and interrupts the CPU once per word. The CPU pops the word with int_ack.
- Outbound: captures cpu_data_out on a decoded write strobe into an output register, drained by an external valid/ready consumer.

Parameters:
- DEPTH, 4, inbound FIFO entries (power of 2, 2..16).
- HOLDOFF, 3, idle cycles after an ack before the next interrupt, covering jump-control pipeline drain.
- TIMEOUT, 64, cycles to wait for an ack before re-pulsing (IRQ_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ext_in_data  in  16  inbound word.
- ext_in_valid  in  1  inbound word valid.
- ext_in_ready  out  1  FIFO not full.
- cpu_data_in  out  16  FIFO head word; 16'h0000 when empty.
- interrupt  out  1  one-cycle interrupt pulse to the CPU.
- int_ack  in  1  CPU consumed head word; pops the FIFO.
- irq_mask  in  1  1 = suppress new interrupt pulses.
- cpu_data_out  in  16  CPU output word.
- cpu_out_wr  in  1  capture cpu_data_out this cycle.
- ext_out_data  out  16  outbound word.
- ext_out_valid  out  1  outbound register holds a word.
- ext_out_ready  in  1  consumer accepts the word.
- in_count  out  log2(DEPTH)+1  inbound FIFO occupancy.
- overflow  out  1  sticky: a CPU write was lost.

Behaviour:
- Reset (sync, active-high, clk rising edge):
  - FIFO emptied, in_count=0, ext_in_ready=1, cpu_data_in=0, interrupt=0.
  - ext_out_valid=0, ext_out_data=0, overflow=0, FSM=IDLE.
  - Reset mid-transfer discards all buffered words with no pulse or handshake completion.
- Inbound push:
  - Occurs when ext_in_valid && ext_in_ready; word is visible on cpu_data_in the next cycle if the FIFO was empty.
  - ext_in_ready = (in_count != DEPTH), combinational from registered count.
- Pop: int_ack while in_count>0. int_ack while empty is ignored (no underflow, count stays 0).
- Simultaneous push+pop when full: push is refused (ready=0 that cycle), pop proceeds.
- Simultaneous push+pop otherwise: count unchanged.
- Pointers wrap modulo DEPTH.
- Interrupt FSM:
  - IDLE: if in_count>0 && !irq_mask -> PULSE.
  - PULSE: interrupt=1 for exactly one cycle -> WAIT_ACK.
  - WAIT_ACK: on int_ack -> HOLD (counter loaded with HOLDOFF).
  - HOLD: count down; at 0 -> IDLE. int_ack in HOLD still pops with no state effect.
  - irq_mask raised in WAIT_ACK does not cancel the wait.
  - int_ack arriving in the same cycle as PULSE is honoured: pop, then -> HOLD.
- Outbound:
  - cpu_out_wr when !ext_out_valid, or when ext_out_ready is high in the same cycle: load ext_out_data, ext_out_valid=1.
  - cpu_out_wr when ext_out_valid && !ext_out_ready: word dropped, overflow set; overflow cleared only by reset.
  - ext_out_valid && ext_out_ready with no write: ext_out_valid=0 next cycle.
  - ext_out_data holds its value while valid.
- Latency:
  - External push to interrupt pulse: 2 cycles when IDLE and unmasked.
  - CPU write to ext_out_valid: 1 cycle.

Optional Feature:
- Macro: CPU_IO_IRQ_TIMEOUT_EN.
- Defined: WAIT_ACK runs a counter; after TIMEOUT cycles with no int_ack it returns to PULSE (re-pulse), counter reloaded. Repeats indefinitely while unacked.
- Not defined: WAIT_ACK waits forever, no counter logic present.

Decomposition:
- Shared package cpu_io_pkg: FSM state encoding (IDLE, PULSE, WAIT_ACK, HOLD), WORD_W=16, default DEPTH/HOLDOFF/TIMEOUT constants.
- One sub-module: io_sync_fifo (parametric DEPTH x 16, push/pop/count/full/empty, show-ahead head).
- Interrupt FSM and outbound register live in the top.

Test Plan:
- Reset then push 16'hA5A5 -> cpu_data_in=A5A5 next cycle; interrupt single pulse 2 cycles after push; int_ack -> in_count=0, cpu_data_in=0; no new pulse for HOLDOFF=3 cycles.
- Push 5 words with DEPTH=4, no acks -> ext_in_ready=0 after the 4th; 5th held until an ack frees a slot; pop order 1,2,3,4,5.
- irq_mask=1 with 2 words queued -> no pulse; drop mask -> pulse within 1 cycle; ack both -> exactly 2 pulses total, separated by at least HOLDOFF+2 cycles.
- cpu_out_wr 16'h1234 with ext_out_ready=0, then cpu_out_wr 16'h5678 -> ext_out_data stays 1234, overflow=1; ready=1 -> valid drops; overflow stays 1 until reset.
- cpu_out_wr on the same cycle as a drain (ready=1, valid=1) -> new word loaded, valid stays 1, overflow=0.
- With CPU_IO_IRQ_TIMEOUT_EN, 1 word queued and no ack -> pulses repeat every TIMEOUT+1 cycles; without the macro -> exactly one pulse.
